// File: rtl/picorv32_mem_bridge.sv
// Run controller plus word-wide RAM bridge for the PicoRV32 native memory port:
// configurable RAM read latency, byte-merge writes, range checking and a run watchdog.
module picorv32_mem_bridge #(
  parameter int          ADDR_W  = 15,
  parameter int          RD_LAT  = 1,
  parameter logic [31:0] TIMEOUT = 32'd0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              finish,
  output logic [1:0]        status,
  output logic              range_err,
  output logic [31:0]       run_cycles,
  output logic              core_resetn,
  input  logic              core_trap,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  input  logic [31:0]       a_in,
  output logic [31:0]       a_out,
  output logic [ADDR_W-1:0] a_addr,
  output logic              a_we
);

  typedef enum logic [1:0] {C_IDLE = 2'd0, C_RUN = 2'd1, C_DONE = 2'd2} ctrl_e;
  typedef enum logic [2:0] {
    M_IDLE = 3'd0, M_READ = 3'd1, M_MERGE = 3'd2, M_WRITE = 3'd3, M_ERR = 3'd4
  } mem_e;

  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  ctrl_e       ctrl_q, ctrl_d;
  mem_e        mem_q, mem_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic [1:0]  status_q, status_d;
  logic        finish_q, finish_d;
  logic        range_err_q, range_err_d;
  logic        core_resetn_q, core_resetn_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic        timeout_hit_s, run_end_s, mem_run_s, out_of_range_s, range_set_s;
  logic        unused_ok;

  assign unused_ok = ^mem_addr[1:0];

  // Run-ending conditions; the memory side stops accepting work on the cycle the run ends.
  always_comb begin
    timeout_hit_s  = (TIMEOUT != 32'd0) && (run_cycles_q == TIMEOUT - 32'd1);
    run_end_s      = (ctrl_q == C_RUN) && (core_trap || timeout_hit_s);
    mem_run_s      = (ctrl_q == C_RUN) && !run_end_s;
    out_of_range_s = (mem_addr >> (ADDR_W + 2)) != 32'd0;
  end

  // Control FSM next state: IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    ctrl_d        = ctrl_q;
    run_cycles_d  = run_cycles_q;
    status_d      = status_q;
    finish_d      = 1'b0;
    core_resetn_d = 1'b0;
    case (ctrl_q)
      C_IDLE: begin
        if (start) begin
          ctrl_d        = C_RUN;
          run_cycles_d  = 32'd0;
          status_d      = 2'b00;
          core_resetn_d = 1'b1;
        end else begin
          ctrl_d = C_IDLE;
        end
      end
      C_RUN: begin
        run_cycles_d = (run_cycles_q == 32'hFFFF_FFFF) ? run_cycles_q : run_cycles_q + 32'd1;
        // Trap has priority over a coinciding timeout.
        if (core_trap) begin
          ctrl_d   = C_DONE;
          finish_d = 1'b1;
          status_d = range_err_q ? 2'b11 : 2'b01;
        end else if (timeout_hit_s) begin
          ctrl_d   = C_DONE;
          finish_d = 1'b1;
          status_d = 2'b10;
        end else begin
          core_resetn_d = 1'b1;
        end
      end
      C_DONE:  ctrl_d = C_IDLE;
      default: ctrl_d = C_IDLE;
    endcase
  end

  // Memory FSM next state; ready/we are computed one cycle ahead so they come out registered.
  always_comb begin
    mem_d       = mem_q;
    cnt_d       = cnt_q;
    merge_d     = merge_q;
    ready_d     = 1'b0;
    we_d        = 1'b0;
    range_set_s = 1'b0;
    if (!mem_run_s) begin
      mem_d = M_IDLE;
      cnt_d = 2'd0;
    end else begin
      case (mem_q)
        M_IDLE: begin
          if (!mem_valid) begin
            mem_d = M_IDLE;
          end else if (out_of_range_s) begin
            mem_d       = M_ERR;
            ready_d     = 1'b1;
            range_set_s = 1'b1;
          end else if (mem_wstrb == 4'hF) begin
            mem_d   = M_WRITE;
            ready_d = 1'b1;
            we_d    = 1'b1;
          end else begin
            mem_d   = M_READ;
            cnt_d   = 2'd0;
            ready_d = (mem_wstrb == 4'h0) && (LAST_CNT == 2'd0);
          end
        end
        M_READ: begin
          if (cnt_q != LAST_CNT) begin
            cnt_d   = cnt_q + 2'd1;
            ready_d = (mem_wstrb == 4'h0) && (cnt_q + 2'd1 == LAST_CNT);
          end else if (mem_wstrb == 4'h0) begin
            mem_d = M_IDLE;
          end else begin
            mem_d   = M_MERGE;
            merge_d = merge_word(a_in, mem_wdata, mem_wstrb);
            ready_d = 1'b1;
            we_d    = 1'b1;
          end
        end
        M_MERGE: mem_d = M_IDLE;
        M_WRITE: mem_d = M_IDLE;
        M_ERR:   mem_d = M_IDLE;
        default: mem_d = M_IDLE;
      endcase
    end
    if ((ctrl_q == C_IDLE) && start) begin
      range_err_d = 1'b0;
    end else begin
      range_err_d = range_err_q | range_set_s;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q        <= C_IDLE;
      mem_q         <= M_IDLE;
      cnt_q         <= 2'd0;
      merge_q       <= 32'd0;
      run_cycles_q  <= 32'd0;
      status_q      <= 2'b00;
      finish_q      <= 1'b0;
      range_err_q   <= 1'b0;
      core_resetn_q <= 1'b0;
      ready_q       <= 1'b0;
      we_q          <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      mem_q         <= mem_d;
      cnt_q         <= cnt_d;
      merge_q       <= merge_d;
      run_cycles_q  <= run_cycles_d;
      status_q      <= status_d;
      finish_q      <= finish_d;
      range_err_q   <= range_err_d;
      core_resetn_q <= core_resetn_d;
      ready_q       <= ready_d;
      we_q          <= we_d;
    end
  end

  // RAM-side data paths follow the current memory state.
  always_comb begin
    if (mem_q == M_MERGE) begin
      a_out = merge_q;
    end else begin
      a_out = mem_wdata;
    end
    if (mem_q == M_ERR) begin
      mem_rdata = 32'd0;
    end else begin
      mem_rdata = a_in;
    end
  end

  assign a_addr      = mem_addr[ADDR_W+1:2];
  assign a_we        = we_q;
  assign mem_ready   = ready_q;
  assign finish      = finish_q;
  assign status      = status_q;
  assign range_err   = range_err_q;
  assign run_cycles  = run_cycles_q;
  assign core_resetn = core_resetn_q;

endmodule

// File: tb/tb_picorv32_mem_bridge.sv
// Randomized self-checking bench: two bridge instances (default and RD_LAT=3/TIMEOUT=100)
// driven as a PicoRV32 core would, checked against a byte-level memory model.
module tb_picorv32_mem_bridge;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        start[2], trap[2], valid[2];
  logic [31:0] addr[2], wdata[2];
  logic [3:0]  wstrb[2];
  logic        finish_w[2], rerr_w[2], cresetn_w[2], ready_w[2], we_w[2];
  logic [1:0]  status_w[2];
  logic [31:0] cyc_w[2], rdata_w[2], ain[2], aout_w[2];
  logic [14:0] aaddr_w[2];
  logic [31:0] ram[2][32768];
  logic [31:0] pipe[2][3];
  int          ncyc = 0;
  int          checks = 0;
  int          failures = 0;

  picorv32_mem_bridge u0 (
    .clock(clock), .reset(reset), .start(start[0]), .finish(finish_w[0]),
    .status(status_w[0]), .range_err(rerr_w[0]), .run_cycles(cyc_w[0]),
    .core_resetn(cresetn_w[0]), .core_trap(trap[0]), .mem_valid(valid[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
    .mem_ready(ready_w[0]), .mem_rdata(rdata_w[0]), .a_in(ain[0]),
    .a_out(aout_w[0]), .a_addr(aaddr_w[0]), .a_we(we_w[0])
  );

  picorv32_mem_bridge #(.ADDR_W(15), .RD_LAT(3), .TIMEOUT(32'd100)) u1 (
    .clock(clock), .reset(reset), .start(start[1]), .finish(finish_w[1]),
    .status(status_w[1]), .range_err(rerr_w[1]), .run_cycles(cyc_w[1]),
    .core_resetn(cresetn_w[1]), .core_trap(trap[1]), .mem_valid(valid[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
    .mem_ready(ready_w[1]), .mem_rdata(rdata_w[1]), .a_in(ain[1]),
    .a_out(aout_w[1]), .a_addr(aaddr_w[1]), .a_we(we_w[1])
  );

  // Synchronous RAMs: u0 has one cycle of read latency, u1 three.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (we_w[i]) ram[i][aaddr_w[i]] <= aout_w[i];
      pipe[i][0] <= ram[i][aaddr_w[i]];
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  assign ain[0] = pipe[0][0];
  assign ain[1] = pipe[1][2];

  always @(posedge clock) ncyc <= ncyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One core request; lat = cycles from request to ack (0 if none), wes = a_we pulses seen.
  task automatic do_req(input int u, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output int lat,
                        output int wes, output logic [31:0] aa);
    @(negedge clock);
    addr[u] = a; wdata[u] = wd; wstrb[u] = ws; valid[u] = 1'b1;
    lat = 0; wes = 0; rd = 32'd0; aa = 32'd0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clock);
      if (we_w[u]) wes++;
      if (ready_w[u]) begin
        lat = k; rd = rdata_w[u]; aa = 32'(aaddr_w[u]);
      end
    end
    valid[u] = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (we_w[u]) wes++;
      if (ready_w[u]) lat = 99;
    end
  endtask

  task automatic do_start(input int u, output int base);
    @(negedge clock);
    check("resetn_before_start", 32'(cresetn_w[u]), 32'd0);
    start[u] = 1'b1;
    @(negedge clock);
    start[u] = 1'b0;
    base = ncyc;
    check("resetn_after_start", 32'(cresetn_w[u]), 32'd1);
    check("cycles_cleared", cyc_w[u], 32'd0);
    check("status_cleared", 32'(status_w[u]), 32'd0);
    check("rerr_cleared", 32'(rerr_w[u]), 32'd0);
  endtask

  logic [31:0] mdl[16];
  logic [31:0] a, wd, mask, rd, aa;
  logic [3:0]  ws;
  logic        oor, m_rerr;
  int          w, kind, lat, wes, base, exp_lat, nfin, fin_idx;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; trap[i] = 1'b0; valid[i] = 1'b0;
      addr[i] = 32'd0; wdata[i] = 32'd0; wstrb[i] = 4'd0;
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check("reset_flags", {25'd0, finish_w[i], status_w[i], rerr_w[i], cresetn_w[i],
                            ready_w[i], we_w[i]}, 32'd0);
      check("reset_cycles", cyc_w[i], 32'd0);
    end
    reset = 1'b0;

    // u0: word store then load
    do_start(0, base);
    do_req(0, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, wes, aa);
    check("sw_lat", 32'(lat), 32'd1);
    check("sw_we", 32'(wes), 32'd1);
    check("sw_addr", aa, 32'd4);
    do_req(0, 32'h10, 32'd0, 4'h0, rd, lat, wes, aa);
    check("lw_lat", 32'(lat), 32'd1);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_we", 32'(wes), 32'd0);

    // u0: fill model words, then random traffic
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      do_req(0, 32'(i * 4), wd, 4'hF, rd, lat, wes, aa);
      mdl[i] = wd;
      check("fill_lat", 32'(lat), 32'd1);
      check("fill_we", 32'(wes), 32'd1);
    end
    m_rerr = 1'b0;
    for (int n = 0; n < 60; n++) begin
      w    = int'($urandom_range(0, 15));
      oor  = ($urandom_range(0, 7) == 0);
      kind = int'($urandom_range(0, 2));
      wd   = $urandom;
      ws   = (kind == 0) ? 4'h0 : (kind == 1) ? 4'hF : 4'($urandom_range(1, 14));
      a    = 32'(w * 4) | 32'($urandom_range(0, 3));
      if (oor) a = a | (32'($urandom_range(1, 32767)) << 17);
      do_req(0, a, wd, ws, rd, lat, wes, aa);
      mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
      if (oor) begin
        exp_lat = 1;
        m_rerr  = 1'b1;
        check("oor_data", rd, 32'd0);
        check("oor_we", 32'(wes), 32'd0);
      end else if (ws == 4'h0) begin
        exp_lat = 1;
        check("rnd_load", rd, mdl[w]);
        check("rnd_load_we", 32'(wes), 32'd0);
      end else begin
        exp_lat = (ws == 4'hF) ? 1 : 2;
        mdl[w]  = (mdl[w] & ~mask) | (wd & mask);
        check("rnd_store_we", 32'(wes), 32'd1);
      end
      check("rnd_lat", 32'(lat), 32'(exp_lat));
      check("rnd_rerr", 32'(rerr_w[0]), 32'(m_rerr));
    end
    for (int i = 0; i < 16; i++) begin
      do_req(0, 32'(i * 4), 32'd0, 4'h0, rd, lat, wes, aa);
      check("final_word", rd, mdl[i]);
    end

    // u0: directed out-of-range load, then trap reports 11
    do_req(0, 32'h0002_0000, 32'd0, 4'h0, rd, lat, wes, aa);
    check("range_lat", 32'(lat), 32'd1);
    check("range_data", rd, 32'd0);
    check("range_we", 32'(wes), 32'd0);
    check("range_flag", 32'(rerr_w[0]), 32'd1);
    @(negedge clock);
    lat = ncyc - base;
    trap[0] = 1'b1;
    @(negedge clock);
    trap[0] = 1'b0;
    check("trap_finish", 32'(finish_w[0]), 32'd1);
    check("trap_status_rerr", 32'(status_w[0]), 32'd3);
    check("trap_cycles", cyc_w[0], 32'(lat + 1));
    check("trap_resetn", 32'(cresetn_w[0]), 32'd0);
    @(negedge clock);
    check("finish_pulse", 32'(finish_w[0]), 32'd0);
    check("cycles_held", cyc_w[0], 32'(lat + 1));

    // u1: sb with RD_LAT=3
    do_start(1, base);
    do_req(1, 32'h10, 32'h11223344, 4'hF, rd, lat, wes, aa);
    check("l3_sw_lat", 32'(lat), 32'd1);
    do_req(1, 32'h11, 32'hAAAAAAAA, 4'b0010, rd, lat, wes, aa);
    check("sb_lat", 32'(lat), 32'd4);
    check("sb_we", 32'(wes), 32'd1);
    check("sb_ram", ram[1][4], 32'h1122AA44);
    do_req(1, 32'h10, 32'd0, 4'h0, rd, lat, wes, aa);
    check("l3_lw_lat", 32'(lat), 32'd3);
    check("l3_lw_data", rd, 32'h1122AA44);

    // u1: trap during the read phase of a partial write drops it
    @(negedge clock);
    addr[1] = 32'h10; wdata[1] = 32'h55555555; wstrb[1] = 4'b0001; valid[1] = 1'b1;
    @(negedge clock);
    trap[1] = 1'b1;
    @(negedge clock);
    trap[1] = 1'b0;
    check("abort_finish", 32'(finish_w[1]), 32'd1);
    check("abort_status", 32'(status_w[1]), 32'd1);
    wes = 0; lat = 0;
    for (int k = 0; k < 6; k++) begin
      if (we_w[1]) wes++;
      if (ready_w[1]) lat++;
      if (k == 2) valid[1] = 1'b0;
      @(negedge clock);
    end
    check("abort_we", 32'(wes), 32'd0);
    check("abort_ready", 32'(lat), 32'd0);
    check("abort_ram", ram[1][4], 32'h1122AA44);

    // u1: clean restart, then spin into the watchdog
    do_start(1, base);
    do_req(1, 32'h10, 32'd0, 4'h0, rd, lat, wes, aa);
    check("restart_lat", 32'(lat), 32'd3);
    check("restart_data", rd, 32'h1122AA44);
    nfin = 0; fin_idx = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (finish_w[1]) begin
        nfin++;
        if (fin_idx < 0) begin
          fin_idx = ncyc - base;
          check("to_status", 32'(status_w[1]), 32'd2);
          check("to_cycles", cyc_w[1], 32'd100);
          check("to_resetn", 32'(cresetn_w[1]), 32'd0);
        end
      end
    end
    check("to_finish_count", 32'(nfin), 32'd1);
    check("to_finish_cycle", 32'(fin_idx), 32'd100);

    // u1: trap on the timeout cycle -> trap wins
    do_start(1, base);
    while (ncyc - base < 99) @(negedge clock);
    trap[1] = 1'b1;
    @(negedge clock);
    trap[1] = 1'b0;
    check("tie_finish", 32'(finish_w[1]), 32'd1);
    check("tie_status", 32'(status_w[1]), 32'd1);
    check("tie_cycles", cyc_w[1], 32'd100);

    // u0: reset during a partial write blocks the write
    do_start(0, base);
    @(negedge clock);
    addr[0] = 32'h20; wdata[0] = 32'hFFFFFFFF; wstrb[0] = 4'b1000; valid[0] = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    wes = 0;
    repeat (3) begin
      @(negedge clock);
      if (we_w[0]) wes++;
    end
    valid[0] = 1'b0;
    check("rst_we", 32'(wes), 32'd0);
    check("rst_resetn", 32'(cresetn_w[0]), 32'd0);
    check("rst_cycles", cyc_w[0], 32'd0);
    check("rst_ram", ram[0][8], mdl[8]);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_bridge.md
# picorv32_mem_bridge

Parametrised run controller and memory bridge between a PicoRV32 native memory interface and one single-port, word-wide synchronous RAM port. It generalises the fixed 15-bit, one-cycle adapter in three ways:
- configurable RAM address width and read latency;
- correct read-modify-write for any byte strobe pattern, with out-of-range access detection;
- a run watchdog with exit status and a cycle counter.

It sits between the accelerator start/finish handshake, the instantiated core and the host-visible RAM.

## Interface
Parameters:
- `ADDR_W`, 15, RAM word-address width; the RAM covers byte addresses 0 .. 2^(ADDR_W+2)-1.
- `RD_LAT`, 1, RAM read latency in cycles, 1..4.
- `TIMEOUT`, 0, watchdog limit in RUN cycles (32-bit); 0 disables it.

Ports (name, direction, width, meaning):
- `clock` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: launches a run; sampled in IDLE only.
- `finish` out 1: one-cycle pulse when the run ends.
- `status` out 2: exit cause; 00 none, 01 trap, 10 timeout, 11 trap with range error. Held until the next start.
- `range_err` out 1: sticky flag, set by any out-of-range access; cleared on start.
- `run_cycles` out 32: cycles spent in RUN; held after finish.
- `core_resetn` out 1: core reset, active-low. High only in RUN.
- `core_trap` in 1: core trap output.
- `mem_valid` in 1, `mem_addr` in 32, `mem_wdata` in 32, `mem_wstrb` in 4: core request.
- `mem_ready` out 1, `mem_rdata` out 32: response to the core.
- `a_in` in 32: RAM read data.
- `a_out` out 32: RAM write data.
- `a_addr` out ADDR_W: RAM word address.
- `a_we` out 1: RAM write enable.

## Operation
Control FSM (IDLE, RUN, DONE):
- IDLE -> RUN on `start`. This transition clears `run_cycles`, `status` and `range_err`.
- RUN -> DONE on `core_trap`, or when `run_cycles` == `TIMEOUT`-1 with `TIMEOUT` != 0.
- If trap and timeout occur in the same cycle, trap wins.
- DONE -> IDLE unconditionally; `finish` = 1 in DONE only.
- `run_cycles` increments every RUN cycle and saturates at 2^32-1.

Memory FSM (M_IDLE, M_READ, M_MERGE, M_WRITE, M_ERR). Requests are accepted in M_IDLE only, and only while the control FSM is in RUN.
- Out of range: `mem_addr[31:ADDR_W+2]` != 0 -> M_ERR. Set `range_err`, assert `mem_ready` with `mem_rdata` = 0, never assert `a_we`.
- `wstrb` = 4'hF -> M_WRITE: `a_we` = 1, `a_out` = `mem_wdata`, `mem_ready` = 1.
- Any other `wstrb` -> M_READ, which counts `RD_LAT` cycles with the address held.
- From M_READ, `wstrb` = 0: assert `mem_ready` with `mem_rdata` = `a_in` on the last count cycle, then return to M_IDLE.
- From M_READ, partial `wstrb`: on the last count cycle, register the merged word (per lane i: `wstrb[i]` ? `wdata` byte : `a_in` byte) and go to M_MERGE. M_MERGE then writes: `a_we` = 1, `a_out` = merged register, `mem_ready` = 1.
- Every response state returns to M_IDLE the next cycle. `mem_ready` is a one-cycle pulse.
- `a_addr` = `mem_addr[ADDR_W+1:2]` (combinational, truncated).
- `a_out` = `mem_wdata` outside write states.
- `mem_rdata` = `a_in` except in M_ERR.
- Aborts: while the control FSM is not in RUN, the memory FSM is forced to M_IDLE on the next edge. A partial transaction is dropped with no `a_we`. A write state coinciding with the trap cycle still completes.
- `status` = 11 when trap ends a run with `range_err` set.

## Timing
- Request visible in cycle N: full write acks in N+1; read acks in N+`RD_LAT`; partial write acks and writes in N+`RD_LAT`+1.
- `core_resetn` rises the cycle after `start` is sampled. `finish` rises 1 cycle after the terminating event.
- Reset values:
  - 0: `finish`, `status`, `range_err`, `run_cycles`, `core_resetn`, `mem_ready`, `a_we`.
  - Both FSMs in their idle state.
  - `a_addr`, `a_out` and `mem_rdata` are combinational as defined above.
- `reset` mid-run returns to IDLE within one cycle, with no write issued after the reset edge.
- `start` during RUN or DONE is ignored.

## Test plan
- Default parameters, core stores word 0xDEADBEEF to 0x10 then loads it: `a_we` in N+1 with `a_addr` = 4; load returns 0xDEADBEEF in N+1.
- `RD_LAT`=3; RAM word 4 holds 0x11223344; `sb` 0xAA to byte address 0x11: ack at N+4, RAM word becomes 0x1122AA44, exactly one `a_we` pulse.
- Load from 0x00020000 with `ADDR_W`=15: `mem_rdata` = 0, no `a_we`, `range_err` = 1; later trap gives `status` = 11.
- `TIMEOUT`=100 with the core spinning: `finish` pulses once, `status` = 10, `run_cycles` = 100, `core_resetn` falls.
- Trap and timeout in the same cycle: `status` = 01.
- Trap asserted during M_READ of a partial write: no `a_we`, FSM back in M_IDLE; a second `start` runs cleanly with `status`, `range_err` and `run_cycles` cleared.
